// File: rtl/syndrome_stream_packer.sv
// Buffers measurement rounds in a small FIFO and serialises each decoding frame
// (header byte, then GRID_WIDTH_U rounds packed LSB-first) onto an 8-bit valid/ready stream.
module syndrome_stream_packer #(
  parameter int          GRID_WIDTH_X = 4,
  parameter int          GRID_WIDTH_Z = 1,
  parameter int          GRID_WIDTH_U = 3,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [7:0]  HEADER_BYTE  = 8'h01,
  localparam int ROUND_BITS      = GRID_WIDTH_X * GRID_WIDTH_Z,
  localparam int BYTES_PER_ROUND = (ROUND_BITS + 7) / 8,
  localparam int LEVEL_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ROUND_BITS-1:0] meas_data,
  input  logic                  meas_valid,
  output logic                  meas_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic [LEVEL_W-1:0]    fifo_level
);

  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int PAD_BITS    = BYTES_PER_ROUND * 8 - ROUND_BITS;
  localparam int BYTE_CNT_W  = (BYTES_PER_ROUND > 1) ? $clog2(BYTES_PER_ROUND) : 1;
  localparam int ROUND_CNT_W = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LEVEL_W-1:0]       level_q, level_d;
  logic [BYTE_CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [ROUND_CNT_W-1:0]   round_cnt_q, round_cnt_d;
  logic                     active_q;

  logic [ROUND_BITS-1:0]    mem_q [FIFO_DEPTH];
  logic [ROUND_BITS-1:0]    head;
  logic [BYTES_PER_ROUND*8-1:0] head_padded;
  logic [7:0]               lanes [BYTES_PER_ROUND];
  logic [7:0]               cur_byte;

  logic full, empty, push, pop, last_byte, last_round;

  // Acceptance is gated by active_q so meas_ready stays low while reset is held.
  assign full       = (level_q == LEVEL_W'(FIFO_DEPTH));
  assign empty      = (level_q == '0);
  assign meas_ready = active_q && !full;
  assign push       = meas_valid && meas_ready;
  assign fifo_level = level_q;
  assign last_byte  = (byte_cnt_q == BYTE_CNT_W'(BYTES_PER_ROUND - 1));
  assign last_round = (round_cnt_q == ROUND_CNT_W'(GRID_WIDTH_U - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= meas_data;
    end
  end

  assign head = mem_q[rd_ptr_q];

  generate
    if (PAD_BITS > 0) begin : g_pad
      assign head_padded = {{PAD_BITS{1'b0}}, head};
    end else begin : g_nopad
      assign head_padded = head;
    end
  endgenerate

  for (genvar gi = 0; gi < BYTES_PER_ROUND; gi++) begin : g_lane
    assign lanes[gi] = head_padded[8*gi +: 8];
  end

  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < BYTES_PER_ROUND; i++) begin
      if (byte_cnt_q == BYTE_CNT_W'(i)) begin
        cur_byte = lanes[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    round_cnt_d = round_cnt_q;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    frame_done  = 1'b0;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        out_valid = 1'b1;
        out_data  = HEADER_BYTE;
        if (out_ready) begin
          state_d     = ST_PAYLOAD;
          byte_cnt_d  = '0;
          round_cnt_d = '0;
        end
      end
      ST_PAYLOAD: begin
        // An empty FIFO stalls the frame in place rather than ending it.
        if (!empty) begin
          out_valid = 1'b1;
          out_data  = cur_byte;
          if (out_ready) begin
            if (last_byte) begin
              pop        = 1'b1;
              byte_cnt_d = '0;
              if (last_round) begin
                frame_done  = 1'b1;
                round_cnt_d = '0;
                state_d     = ST_IDLE;
              end else begin
                round_cnt_d = round_cnt_q + ROUND_CNT_W'(1);
              end
            end else begin
              byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    level_d  = level_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LEVEL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LEVEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      byte_cnt_q  <= '0;
      round_cnt_q <= '0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      byte_cnt_q  <= byte_cnt_d;
      round_cnt_q <= round_cnt_d;
      active_q    <= 1'b1;
    end
  end

endmodule
